mac3_pipe: RTL and testbench

- Parametrised, fully pipelined three-operand arithmetic unit: the next generation of the team's A/B/C → Q top-level datapath.
- Adds the following over the fixed-width predecessor:
  - configurable widths
  - per-sample mode select
  - valid handshake
  - a running accumulator
  - an overflow flag
- Sits between operand registers and the result bus; accepts one sample per cycle.

---
 rtl/mac3_pkg.sv | 22 ++
 rtl/mac3_mult.sv | 22 ++
 rtl/mac3_pipe.sv | 119 +++++++++++
 tb/tb_mac3_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mac3_pkg.sv
// rtl/mac3_pkg.sv - shared encodings and stage payload for the mac3 datapath
package mac3_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 36;

    typedef enum logic [1:0] {
        MODE_MULADD = 2'b00,
        MODE_ADD3   = 2'b01,
        MODE_ACC    = 2'b10,
        MODE_MULSUB = 2'b11
    } mode_t;

    // Control part of a stage payload; operand fields are sized by the
    // instantiating module since their width is a module parameter.
    typedef struct packed {
        mode_t mode;
        logic  acc_clr;
        logic  valid;
    } stage_ctrl_t;

endpackage

// File: rtl/mac3_mult.sv
// rtl/mac3_mult.sv - registered unsigned IN_W x IN_W multiplier (stage S2)
module mac3_mult
    import mac3_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    output logic [2*IN_W-1:0] prod
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod <= '0;
        end else begin
            prod <= {{IN_W{1'b0}}, a} * {{IN_W{1'b0}}, b};
        end
    end

endmodule

// File: rtl/mac3_pipe.sv
// rtl/mac3_pipe.sv - three-stage A/B/C -> Q arithmetic pipe with accumulator
module mac3_pipe
    import mac3_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    input  logic [IN_W-1:0]  A_in,
    input  logic [IN_W-1:0]  B_in,
    input  logic [IN_W-1:0]  C_in,
    output logic [OUT_W-1:0] Q,
    output logic             valid_out,
    output logic             ovf
);

    localparam int FW = 2*IN_W + 2;

    if (LAT != 3) begin : g_lat_chk
        $error("mac3_pipe: only LAT=3 is supported");
    end
    if (OUT_W < IN_W + 1 || OUT_W > 2*IN_W + 1) begin : g_out_w_chk
        $error("mac3_pipe: OUT_W must lie in IN_W+1 .. 2*IN_W+1");
    end

    logic [IN_W-1:0]   s1_a, s1_b, s1_c;
    stage_ctrl_t       s1_ctrl;

    logic [2*IN_W-1:0] s2_prod;
    logic [IN_W:0]     s2_sum;
    logic [IN_W-1:0]   s2_c;
    stage_ctrl_t       s2_ctrl;

    logic [OUT_W-1:0]  acc;

    logic [FW-1:0]     s3_lhs, s3_c, s3_acc_base, s3_full;
    logic              s3_under, s3_ovf;

    // S1: operand and control capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_c    <= '0;
            s1_ctrl <= '0;
        end else begin
            s1_a    <= A_in;
            s1_b    <= B_in;
            s1_c    <= C_in;
            s1_ctrl <= '{mode: mode_t'(mode), acc_clr: acc_clr, valid: valid_in};
        end
    end

    // S2: product in the sub-module, A+B alongside for ADD3
    mac3_mult #(.IN_W(IN_W)) u_mult (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (s1_a),
        .b    (s1_b),
        .prod (s2_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_sum  <= '0;
            s2_c    <= '0;
            s2_ctrl <= '0;
        end else begin
            s2_sum  <= {1'b0, s1_a} + {1'b0, s1_b};
            s2_c    <= s1_c;
            s2_ctrl <= s1_ctrl;
        end
    end

    // S3: full-precision combine; the accumulator lives here, so a following
    // ACC sample always sees the value written by the one just before it.
    always_comb begin
        s3_lhs      = (s2_ctrl.mode == MODE_ADD3) ? FW'(s2_sum) : FW'(s2_prod);
        s3_c        = FW'(s2_c);
        s3_acc_base = s2_ctrl.acc_clr ? '0 : FW'(acc);
        s3_full     = '0;
        s3_under    = 1'b0;
        case (s2_ctrl.mode)
            MODE_MULADD,
            MODE_ADD3:   s3_full = s3_lhs + s3_c;
            MODE_ACC:    s3_full = s3_lhs + s3_acc_base;
            MODE_MULSUB: begin
                s3_full  = s3_lhs - s3_c;
                s3_under = (s3_lhs < s3_c);
            end
            default:     s3_full = '0;
        endcase
        s3_ovf = s3_under || (|s3_full[FW-1:OUT_W]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q         <= '0;
            ovf       <= 1'b0;
            valid_out <= 1'b0;
            acc       <= '0;
        end else begin
            valid_out <= s2_ctrl.valid;
            if (s2_ctrl.valid) begin
                Q   <= s3_full[OUT_W-1:0];
                ovf <= s3_ovf;
                if (s2_ctrl.mode == MODE_ACC) begin
                    acc <= s3_full[OUT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac3_pipe.sv
// tb/tb_mac3_pipe.sv - table vectors, reset corner case and random samples vs a reference model
module tb_mac3_pipe;

    localparam int IN_W  = 32;
    localparam int OUT_W = 36;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_in = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              acc_clr = 1'b0;
    logic [IN_W-1:0]   a_in = '0, b_in = '0, c_in = '0;
    logic [OUT_W-1:0]  q;
    logic              valid_out, ovf;

    always #5 clk = ~clk;

    mac3_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .mode     (mode),
        .acc_clr  (acc_clr),
        .A_in     (a_in),
        .B_in     (b_in),
        .C_in     (c_in),
        .Q        (q),
        .valid_out(valid_out),
        .ovf      (ovf)
    );

    typedef struct {
        int               due;
        logic [OUT_W-1:0] q;
        logic             ovf;
    } exp_t;

    typedef struct {
        bit               v;
        logic [1:0]       m;
        bit               clr;
        logic [IN_W-1:0]  a, b, c;
        logic [OUT_W-1:0] eq;
        bit               eo;
    } vec_t;

    exp_t             exp_q[$];
    vec_t             tbl[$];
    int               cyc = 0;
    int               n_chk = 0;
    int               n_fail = 0;
    bit               chk_en = 0;
    logic [OUT_W-1:0] hold_q = '0;
    logic             hold_ovf = 1'b0;
    logic [OUT_W-1:0] m_acc = '0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference: plain wide arithmetic straight from the mode definitions.
    function automatic void model(input logic [1:0] m, input bit clr,
                                  input logic [IN_W-1:0] a, b, c,
                                  output logic [OUT_W-1:0] rq, output logic ro);
        logic [65:0] p, full;
        bit under;
        under = 0;
        p = 66'(a) * 66'(b);
        case (m)
            2'b00: full = p + 66'(c);
            2'b01: full = 66'(a) + 66'(b) + 66'(c);
            2'b10: begin
                full  = (clr ? 66'd0 : 66'(m_acc)) + p;
                m_acc = full[OUT_W-1:0];
            end
            default: begin
                under = (p < 66'(c));
                full  = p - 66'(c);
            end
        endcase
        rq = full[OUT_W-1:0];
        ro = under || (full >= (66'd1 << OUT_W));
    endfunction

    function automatic vec_t mk(bit v, logic [1:0] m, bit clr, logic [IN_W-1:0] a, b, c,
                                logic [OUT_W-1:0] eq, bit eo);
        vec_t r;
        r.v = v; r.m = m; r.clr = clr; r.a = a; r.b = b; r.c = c; r.eq = eq; r.eo = eo;
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            hold_q   = '0;
            hold_ovf = 1'b0;
            chk_en   = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("valid_out", valid_out, 1'b1);
                check("Q", q, exp_q[0].q);
                check("ovf", ovf, exp_q[0].ovf);
                hold_q   = exp_q[0].q;
                hold_ovf = exp_q[0].ovf;
                void'(exp_q.pop_front());
            end else begin
                check("valid_out idle", valid_out, 1'b0);
                check("Q hold", q, hold_q);
                check("ovf hold", ovf, hold_ovf);
            end
        end
    end

    // Called at a negedge; the sample is captured on the next posedge.
    task automatic send(input bit v, input logic [1:0] m, input bit clr,
                        input logic [IN_W-1:0] a, b, c,
                        input logic [OUT_W-1:0] eq, input bit eo, input bit use_model);
        logic [OUT_W-1:0] mq;
        logic             mo;
        exp_t             e;
        valid_in = v; mode = m; acc_clr = clr; a_in = a; b_in = b; c_in = c;
        if (v) begin
            model(m, clr, a, b, c, mq, mo);
            e.due = cyc + 3;
            e.q   = use_model ? mq : eq;
            e.ovf = use_model ? mo : eo;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 2'b00, 0, '0, '0, '0, '0, 0, 0);
    endtask

    task automatic reset_pulse();
        valid_in = 1'b0;
        rst_n    = 1'b0;
        m_acc    = '0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    initial begin
        tbl.push_back(mk(1, 2'b00, 0, 2, 3, 4, 36'd10, 0));
        tbl.push_back(mk(1, 2'b00, 0, 1, 1, 1, 36'd2, 0));
        tbl.push_back(mk(1, 2'b00, 0, 2, 2, 3, 36'd7, 0));
        tbl.push_back(mk(1, 2'b01, 0, 2, 3, 4, 36'd9, 0));
        tbl.push_back(mk(1, 2'b11, 0, 1, 1, 1, 36'd0, 0));
        tbl.push_back(mk(1, 2'b11, 0, 2, 2, 3, 36'd1, 0));
        tbl.push_back(mk(1, 2'b11, 0, 1, 1, 2, 36'hF_FFFF_FFFF, 1));
        tbl.push_back(mk(1, 2'b10, 1, 2, 3, 9, 36'd6, 0));
        tbl.push_back(mk(1, 2'b10, 0, 1, 1, 5, 36'd7, 0));
        tbl.push_back(mk(0, 2'b10, 0, 7, 7, 7, 36'd0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 2, 2, 1, 36'd11, 0));
        tbl.push_back(mk(1, 2'b00, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 36'hE_0000_0001, 1));
        tbl.push_back(mk(1, 2'b00, 0, 2, 3, 4, 36'd10, 0));

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        foreach (tbl[i])
            send(tbl[i].v, tbl[i].m, tbl[i].clr, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].eq, tbl[i].eo, 0);
        idle(4);

        // Two samples in flight, then a one-cycle reset discards both.
        send(1, 2'b00, 0, 2, 3, 4, 36'd10, 0, 0);
        send(1, 2'b01, 0, 2, 3, 4, 36'd9, 0, 0);
        reset_pulse();
        idle(3);
        send(1, 2'b10, 0, 1, 1, 0, 36'd1, 0, 0);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            bit               v, clr;
            logic [1:0]       m;
            logic [IN_W-1:0]  a, b, c;
            v   = ($urandom_range(0, 3) != 0);
            m   = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom; b = $urandom; c = $urandom;
            end else begin
                a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15);
            end
            send(v, m, clr, a, b, c, '0, 0, 1);
        end
        idle(6);
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
